// File: rtl/flappy_game_fsm_if.sv
// -----------------------------------------------------------------------------
// flappy_game_fsm_if
//
// Bundles the game controller's inputs and outputs.
//
// Signals:
//   flap       : debounced flap button level (clk_2ms domain)
//   bird_Y     : bird top edge Y, 0 = top of screen
//   pip_X      : pipe right edge X
//   pip_Y      : bottom edge of the pipe gap
//   score      : current score from the pipe generator
//   state      : game state, 0 = IDLE, 1 = PLAY, 2 = DEAD
//   crash      : one-tick pulse on entry to DEAD
//   best_score : best score latched at any crash since reset
//
// Modports:
//   master : the surroundings (drives the inputs, observes the outputs)
//   slave  : the game controller itself
// -----------------------------------------------------------------------------
interface flappy_game_fsm_if;
   logic       flap;
   logic [8:0] bird_Y;
   logic [9:0] pip_X;
   logic [8:0] pip_Y;
   logic [7:0] score;
   logic [1:0] state;
   logic       crash;
   logic [7:0] best_score;

   modport master (
      output flap,
      output bird_Y,
      output pip_X,
      output pip_Y,
      output score,
      input  state,
      input  crash,
      input  best_score
   );

   modport slave (
      input  flap,
      input  bird_Y,
      input  pip_X,
      input  pip_Y,
      input  score,
      output state,
      output crash,
      output best_score
   );
endinterface

// File: rtl/flappy_game_fsm.sv
// -----------------------------------------------------------------------------
// flappy_game_fsm
//
// Game-state controller for the flappy game. Detects bird/pipe and
// bird/screen-boundary collisions, sequences IDLE -> PLAY -> DEAD -> IDLE,
// enforces a hold-off in DEAD before a flap restarts, and keeps the best score
// seen at any crash since reset. Runs on the 2 ms game tick.
//
// Ports:
//   clk_2ms : game tick clock, all logic on the rising edge
//   rst     : asynchronous, active-high reset
//   bus     : flappy_game_fsm_if.slave
//               in : flap, bird_Y, pip_X, pip_Y, score
//               out: state, crash, best_score (all registered)
//
// Configuration macro:
//   FLAPPY_GOD_MODE_EN : when defined the pipe collision is disabled, so only
//                        the screen boundary ends a game (render/debug aid).
//                        Undefined (default): full collision.
// -----------------------------------------------------------------------------
module flappy_game_fsm #(
   parameter int slot_width  = 60,
   parameter int slot_height = 100,
   parameter int bird_HPos   = 320,
   parameter int bird_Xwidth = 34,
   parameter int bird_Ywidth = 24,
   parameter int screen_H    = 480,
   parameter int dead_hold   = 250
) (
   input  logic               clk_2ms,
   input  logic               rst,
   flappy_game_fsm_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_DEAD = 2'd2,
      S_ILL  = 2'd3
   } state_t;

   // Horizontal overlap window on pip_X (exclusive bounds). Bird spans
   // [bird_HPos-bird_Xwidth, bird_HPos), pipe spans [pip_X-slot_width, pip_X);
   // they overlap when pip_X lies strictly between these two constants.
   localparam logic [10:0] HOV_LO    = 11'(bird_HPos - bird_Xwidth);
   localparam logic [10:0] HOV_HI    = 11'(bird_HPos + slot_width);
   localparam logic [9:0]  GAP_H     = 10'(slot_height);
   localparam logic [9:0]  BIRD_H    = 10'(bird_Ywidth);
   localparam logic [9:0]  SCREEN_H  = 10'(screen_H);
   localparam logic [7:0]  DEAD_HOLD = 8'(dead_hold);

   state_t     state_reg;
   logic       crash_reg;
   logic [7:0] best_score_reg;
   logic [7:0] hold_cnt_reg;
   logic       flap_prev_reg;

   logic        flap_rise;
   logic [10:0] pip_x_ext;
   logic [9:0]  bird_top;
   logic [9:0]  bird_bot;
   logic [9:0]  gap_top;
   logic [9:0]  gap_bot;
   logic        hov;
   logic        phit_raw;
   logic        phit;
   logic        bhit;
   logic        hit;

   // ------------------------------------------------------------------------
   // Flap edge detect. flap_prev resets high so a button held across reset
   // release does not count as a press.
   // ------------------------------------------------------------------------
   assign flap_rise = bus.flap & ~flap_prev_reg;

   // ------------------------------------------------------------------------
   // Collision detect.
   // pip_X is widened and only compared against constants, never subtracted
   // from, so a pipe partly off the left edge cannot wrap into a false hit.
   // ------------------------------------------------------------------------
   assign pip_x_ext = {1'b0, bus.pip_X};
   assign hov       = (pip_x_ext > HOV_LO) && (pip_x_ext < HOV_HI);

   // Vertical checks in 10 bits so bird_Y + bird_Ywidth cannot overflow.
   // pip_Y >= slot_height is guaranteed upstream, so gap_top never wraps.
   assign bird_top = {1'b0, bus.bird_Y};
   assign bird_bot = bird_top + BIRD_H;
   assign gap_bot  = {1'b0, bus.pip_Y};
   assign gap_top  = gap_bot - GAP_H;

   // The bird must sit fully inside [gap_top, gap_bot) while overlapping.
   assign phit_raw = hov && ((bird_top < gap_top) || (bird_bot > gap_bot));

`ifdef FLAPPY_GOD_MODE_EN
   assign phit = 1'b0;
`else
   assign phit = phit_raw;
`endif

   assign bhit = (bus.bird_Y == 9'd0) || (bird_bot >= SCREEN_H);
   assign hit  = phit | bhit;

   // ------------------------------------------------------------------------
   // Game FSM with registered outputs.
   // hold_cnt counts ticks spent in DEAD and saturates at dead_hold; a flap
   // is only honoured once it has saturated, and earlier presses are simply
   // dropped rather than remembered.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_2ms or posedge rst) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         crash_reg      <= 1'b0;
         best_score_reg <= 8'd0;
         hold_cnt_reg   <= 8'd0;
         flap_prev_reg  <= 1'b1;
      end else begin
         flap_prev_reg <= bus.flap;
         crash_reg     <= 1'b0;

         case (state_reg)
            S_IDLE: begin
               if (flap_rise) begin
                  state_reg <= S_PLAY;
               end
            end

            S_PLAY: begin
               // flap is deliberately ignored here; a hit always wins.
               if (hit) begin
                  state_reg    <= S_DEAD;
                  crash_reg    <= 1'b1;
                  hold_cnt_reg <= 8'd0;
                  if (bus.score > best_score_reg) begin
                     best_score_reg <= bus.score;
                  end
               end
            end

            S_DEAD: begin
               if (flap_rise && (hold_cnt_reg == DEAD_HOLD)) begin
                  state_reg    <= S_IDLE;
                  hold_cnt_reg <= 8'd0;
               end else if (hold_cnt_reg != DEAD_HOLD) begin
                  hold_cnt_reg <= hold_cnt_reg + 8'd1;
               end
            end

            default: begin
               // Unreachable code 3: recover to IDLE.
               state_reg    <= S_IDLE;
               hold_cnt_reg <= 8'd0;
            end
         endcase
      end
   end

   assign bus.state      = state_reg;
   assign bus.crash      = crash_reg;
   assign bus.best_score = best_score_reg;

endmodule

// File: tb/tb_flappy_game_fsm.sv
// -----------------------------------------------------------------------------
// tb_flappy_game_fsm
//
// Directed stimulus for flappy_game_fsm. A behavioural model (interval
// geometry in plain integers, ticks-in-DEAD counter without saturation) is
// compared against the DUT outputs on every falling edge; literal checks at
// key points pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_flappy_game_fsm;

   logic clk_2ms = 1'b0;
   logic rst;

   flappy_game_fsm_if bus ();

   flappy_game_fsm dut (
      .clk_2ms (clk_2ms),
      .rst     (rst),
      .bus     (bus.slave)
   );

   always #5 clk_2ms = ~clk_2ms;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;

   // ------------------------------------------------------------------------
   // Behavioural model
   // ------------------------------------------------------------------------
   int m_state;
   bit m_crash;
   int m_best;
   int m_dead_ticks;
   bit m_flap_prev;

   function automatic bit model_hit(int bx_y, int px, int py);
      int bird_l, bird_r, pipe_l, pipe_r;
      bit xov, vout, edge_hit;
      bird_l = 320 - 34;
      bird_r = 320;
      pipe_l = px - 60;
      pipe_r = px;
      xov    = (pipe_l < bird_r) && (pipe_r > bird_l);
      vout   = (bx_y < py - 100) || (bx_y + 24 > py);
      edge_hit = (bx_y == 0) || (bx_y + 24 >= 480);
`ifdef FLAPPY_GOD_MODE_EN
      return edge_hit;
`else
      return (xov && vout) || edge_hit;
`endif
   endfunction

   always @(posedge clk_2ms or posedge rst) begin
      if (rst) begin
         m_state      = 0;
         m_crash      = 0;
         m_best       = 0;
         m_dead_ticks = 0;
         m_flap_prev  = 1;
      end else begin
         bit rise;
         rise    = bus.flap && !m_flap_prev;
         m_crash = 0;
         if (m_state == 0) begin
            if (rise) m_state = 1;
         end else if (m_state == 1) begin
            if (model_hit(int'(bus.bird_Y), int'(bus.pip_X), int'(bus.pip_Y))) begin
               m_state      = 2;
               m_crash      = 1;
               m_dead_ticks = 0;
               if (int'(bus.score) > m_best) m_best = int'(bus.score);
            end
         end else begin
            if (rise && m_dead_ticks >= 250) m_state = 0;
            else m_dead_ticks++;
         end
         m_flap_prev = bus.flap;
      end
   end

   // ------------------------------------------------------------------------
   // Per-cycle compare against the model
   // ------------------------------------------------------------------------
   bit crash_seen;

   always @(negedge clk_2ms) begin
      cycle++;
      if (bus.crash) crash_seen = 1;
      vectors++;
      if (int'(bus.state) != m_state) begin
         miscompares++;
         $display("FAIL model_state cycle %0d: got %0d, want %0d", cycle, bus.state, m_state);
      end
      vectors++;
      if (bus.crash != m_crash) begin
         miscompares++;
         $display("FAIL model_crash cycle %0d: got %0b, want %0b", cycle, bus.crash, m_crash);
      end
      vectors++;
      if (int'(bus.best_score) != m_best) begin
         miscompares++;
         $display("FAIL model_best cycle %0d: got %0d, want %0d", cycle, bus.best_score, m_best);
      end
   end

   // ------------------------------------------------------------------------
   // Literal checks and stimulus helpers
   // ------------------------------------------------------------------------
   task automatic chk(input string name, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("FAIL %s: got %0d, want %0d", name, got, want);
      end else begin
         $display("check %-22s got %0d ok", name, got);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_2ms);
   endtask

   task automatic press();
      bus.flap = 1'b0;
      tick(1);
      bus.flap = 1'b1;
      tick(1);
   endtask

   initial begin
      rst        = 1'b1;
      bus.flap   = 1'b1;
      bus.bird_Y = 9'd230;
      bus.pip_X  = 10'd700;
      bus.pip_Y  = 9'd300;
      bus.score  = 8'd0;
      #3;
      chk("reset_state", int'(bus.state), 0);
      chk("reset_best", int'(bus.best_score), 0);
      tick(3);
      rst = 1'b0;

      // Button held through reset release is not a press.
      tick(4);
      chk("held_flap_idle", int'(bus.state), 0);
      press();
      chk("start_play", int'(bus.state), 1);

      // Gap pass: pipe sweeps through the bird with the bird inside the gap.
      crash_seen = 0;
      for (int x = 700; x >= 0; x--) begin
         bus.pip_X = 10'(x);
         bus.flap  = x[3];
         tick(1);
      end
      chk("gap_pass_state", int'(bus.state), 1);
      chk("gap_pass_no_crash", int'(crash_seen), 0);

      // Pipe hit boundary: 286 is just clear, 287 overlaps.
      bus.flap   = 1'b1;
      bus.bird_Y = 9'd290;
      bus.pip_X  = 10'd286;
      bus.score  = 8'd7;
      tick(3);
      chk("pipx_286_no_hit", int'(bus.state), 1);
      bus.pip_X = 10'd287;
      tick(1);
`ifdef FLAPPY_GOD_MODE_EN
      chk("god_pipx_287_no_hit", int'(bus.state), 1);
      bus.bird_Y = 9'd0;
      tick(1);
`endif
      chk("pipx_287_dead", int'(bus.state), 2);
      chk("crash_pulse", int'(bus.crash), 1);
      chk("best_after_7", int'(bus.best_score), 7);
      bus.pip_X  = 10'd700;
      bus.bird_Y = 9'd230;
      tick(1);
      chk("crash_one_tick", int'(bus.crash), 0);

      // Hold-off: early presses are dropped, press at the exact limit works.
      bus.flap = 1'b0;
      tick(98);
      bus.flap = 1'b1;
      tick(1);
      chk("early_flap_dead", int'(bus.state), 2);
      bus.flap = 1'b0;
      tick(149);
      bus.flap = 1'b1;
      tick(1);
      chk("flap_249_dead", int'(bus.state), 2);
      press();
      chk("flap_250_idle", int'(bus.state), 0);

      // Second game: boundary at the bottom, lower score keeps best.
      bus.score = 8'd3;
      press();
      chk("second_play", int'(bus.state), 1);
      bus.bird_Y = 9'd455;
      tick(2);
      chk("bird_455_play", int'(bus.state), 1);
      bus.bird_Y = 9'd456;
      tick(1);
      chk("bird_456_dead", int'(bus.state), 2);
      chk("best_kept_7", int'(bus.best_score), 7);
      tick(10);

      // Asynchronous reset in the middle of DEAD.
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_state", int'(bus.state), 0);
      chk("async_rst_best", int'(bus.best_score), 0);
      chk("async_rst_crash", int'(bus.crash), 0);
      tick(2);
      rst = 1'b0;
      bus.bird_Y = 9'd230;
      tick(2);

      // Third game: top boundary.
      press();
      chk("third_play", int'(bus.state), 1);
      bus.bird_Y = 9'd0;
      tick(1);
      chk("bird_0_dead", int'(bus.state), 2);
      chk("best_after_rst_3", int'(bus.best_score), 3);
      tick(3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
